// File: rtl/aud_sram_arbiter_if.sv
// Requester handshakes and SRAM pin bundle for the audio SRAM arbiter.
// slave: the arbiter's view; master: the requesters/SRAM side.
interface aud_sram_arbiter_if;
   logic        i_wr_req;
   logic [19:0] i_wr_addr;
   logic [15:0] i_wr_data;
   logic        o_wr_ack;
   logic        i_rd_req;
   logic [19:0] i_rd_addr;
   logic        o_rd_valid;
   logic [15:0] o_rd_data;
   logic [19:0] o_last_wr_addr;
   logic        o_busy;
   logic [19:0] o_SRAM_ADDR;
   logic [15:0] o_sram_dq;
   logic        o_sram_dq_oe;
   logic [15:0] i_sram_dq;
   logic        o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N;

   modport slave (
      input  i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_sram_dq,
      output o_wr_ack, o_rd_valid, o_rd_data, o_last_wr_addr, o_busy,
             o_SRAM_ADDR, o_sram_dq, o_sram_dq_oe,
             o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N
   );

   modport master (
      output i_wr_req, i_wr_addr, i_wr_data, i_rd_req, i_rd_addr, i_sram_dq,
      input  o_wr_ack, o_rd_valid, o_rd_data, o_last_wr_addr, o_busy,
             o_SRAM_ADDR, o_sram_dq, o_sram_dq_oe,
             o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N
   );
endinterface

// File: rtl/aud_sram_arbiter.sv
// Shares one 16-bit async SRAM between the recorder (writes) and the DSP (reads):
// serialised accesses, fixed strobe width, round-robin on conflict, DONE turnaround.
module aud_sram_arbiter #(
   parameter int ACCESS_CYC = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   aud_sram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;
   localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYC - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [19:0] addr_q, addr_d, last_wr_q, last_wr_d;
   logic [15:0] data_q, data_d, rd_data_q, rd_data_d;
   logic        last_w_q, last_w_d;  // 1: write won the most recent grant
   logic        wr_ack_q, wr_ack_d, rd_valid_q, rd_valid_d;
   logic        busy_q, we_n_q, ce_n_q, oe_n_q, dq_oe_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      data_d     = data_q;
      last_w_d   = last_w_q;
      last_wr_d  = last_wr_q;
      rd_data_d  = rd_data_q;
      wr_ack_d   = 1'b0;
      rd_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_wr_req && (!bus.i_rd_req || !last_w_q)) begin
               state_d  = WR;
               addr_d   = bus.i_wr_addr;
               data_d   = bus.i_wr_data;
               cnt_d    = 4'd0;
               last_w_d = 1'b1;
            end else if (bus.i_rd_req) begin
               state_d  = RD;
               addr_d   = bus.i_rd_addr;
               cnt_d    = 4'd0;
               last_w_d = 1'b0;
            end
         end
         WR: begin
            if (cnt_q == CNT_LAST) begin
               state_d   = DONE;
               wr_ack_d  = 1'b1;
               last_wr_d = addr_q;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         RD: begin
            if (cnt_q == CNT_LAST) begin
               state_d    = DONE;
               rd_valid_d = 1'b1;
               rd_data_d  = bus.i_sram_dq;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes are registered from the next state so the pins switch on the edge
   // that enters WR/RD and are released by the edge that enters DONE.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= 20'd0;
         data_q     <= 16'd0;
         last_w_q   <= 1'b0;
         last_wr_q  <= 20'd0;
         rd_data_q  <= 16'd0;
         wr_ack_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         we_n_q     <= 1'b1;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         dq_oe_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         last_w_q   <= last_w_d;
         last_wr_q  <= last_wr_d;
         rd_data_q  <= rd_data_d;
         wr_ack_q   <= wr_ack_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= (state_d != IDLE);
         we_n_q     <= (state_d != WR);
         ce_n_q     <= !((state_d == WR) || (state_d == RD));
         oe_n_q     <= (state_d != RD);
         dq_oe_q    <= (state_d == WR);
      end
   end

   assign bus.o_wr_ack       = wr_ack_q;
   assign bus.o_rd_valid     = rd_valid_q;
   assign bus.o_rd_data      = rd_data_q;
   assign bus.o_last_wr_addr = last_wr_q;
   assign bus.o_busy         = busy_q;
   assign bus.o_SRAM_ADDR    = addr_q;
   assign bus.o_sram_dq      = data_q;
   assign bus.o_sram_dq_oe   = dq_oe_q;
   assign bus.o_SRAM_WE_N    = we_n_q;
   assign bus.o_SRAM_CE_N    = ce_n_q;
   assign bus.o_SRAM_OE_N    = oe_n_q;
   assign bus.o_SRAM_LB_N    = ce_n_q;
   assign bus.o_SRAM_UB_N    = ce_n_q;
endmodule

// File: tb/tb_aud_sram_arbiter.sv
// Bench for aud_sram_arbiter: transaction-timeline reference model, SRAM model,
// directed cases plus random traffic; second instance with ACCESS_CYC=1.
module tb_aud_sram_arbiter;
   localparam int N = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_clr = 1'b1;
   always #5 clk = ~clk;

   aud_sram_arbiter_if ifc();
   aud_sram_arbiter_if ifc1();

   aud_sram_arbiter #(.ACCESS_CYC(N)) u_dut  (.i_clk(clk), .i_rst(rst), .bus(ifc));
   aud_sram_arbiter #(.ACCESS_CYC(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(ifc1));

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [15:0] dflt(input int a);
      if (a == 32) return 16'h1234;
      return (16'(a) * 16'h0101) ^ 16'h5A5A;
   endfunction

   // Physical SRAM model: writes on WE_N low at the clock, reads while OE_N low.
   logic [15:0] sram [256];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) sram[i] <= dflt(i);
      end else if (!ifc.o_SRAM_WE_N && !ifc.o_SRAM_CE_N) begin
         sram[ifc.o_SRAM_ADDR[7:0]] <= ifc.o_sram_dq;
      end
   end
   assign ifc.i_sram_dq = (!ifc.o_SRAM_OE_N && !ifc.o_SRAM_CE_N) ?
                          sram[ifc.o_SRAM_ADDR[7:0]] : 16'hDEAD;

   // Reference model: a grant at cycle g occupies cycles g+1..g+N, done at g+N+1.
   bit          act, gw, last_w, done_w, done_r;
   int          g, cyc;
   logic [19:0] gaddr, m_last_wr;
   logic [15:0] gdata, m_rd_data;
   logic [15:0] ref_mem [256];
   bit          wp, rp, hold_w, hold_r, drop_rd;
   int          pw, pr;

   task automatic cycle_chk();
      bit on, dn;
      on = act && cyc >= g + 1 && cyc <= g + N;
      dn = act && cyc == g + N + 1;
      done_w = dn && gw;
      done_r = dn && !gw;
      if (done_w) m_last_wr = gaddr;
      if (done_r) m_rd_data = ref_mem[gaddr[7:0]];
      chk("busy",    ifc.o_busy,       act && cyc >= g + 1 && cyc <= g + N + 1);
      chk("ce_n",    ifc.o_SRAM_CE_N,  !on);
      chk("we_n",    ifc.o_SRAM_WE_N,  !(on && gw));
      chk("oe_n",    ifc.o_SRAM_OE_N,  !(on && !gw));
      chk("lb_n",    ifc.o_SRAM_LB_N,  !on);
      chk("ub_n",    ifc.o_SRAM_UB_N,  !on);
      chk("dq_oe",   ifc.o_sram_dq_oe, on && gw);
      if (on) chk("addr", ifc.o_SRAM_ADDR, gaddr);
      if (on && gw) chk("dq", ifc.o_sram_dq, gdata);
      chk("wr_ack",  ifc.o_wr_ack,     done_w);
      chk("rd_vld",  ifc.o_rd_valid,   done_r);
      chk("last_wr", ifc.o_last_wr_addr, m_last_wr);
      chk("rd_data", ifc.o_rd_data,    m_rd_data);
   endtask

   task automatic drive();
      if (done_w) wp = hold_w;
      if (done_r) rp = hold_r;
      if (drop_rd && act && !gw && cyc == g + 1) rp = 1'b0;
      if (!wp && pw > 0 && $urandom_range(0, 99) < pw) begin
         wp = 1'b1;
         ifc.i_wr_addr = 20'($urandom_range(0, 63));
         ifc.i_wr_data = 16'($urandom);
      end
      if (!rp && pr > 0 && $urandom_range(0, 99) < pr) begin
         rp = 1'b1;
         ifc.i_rd_addr = 20'($urandom_range(0, 63));
      end
      ifc.i_wr_req = wp;
      ifc.i_rd_req = rp;
   endtask

   task automatic model_grant();
      if (!act || cyc > g + N + 1) begin
         if (wp && (!rp || !last_w)) begin
            act = 1'b1; g = cyc; gw = 1'b1; last_w = 1'b1;
            gaddr = ifc.i_wr_addr; gdata = ifc.i_wr_data;
            ref_mem[gaddr[7:0]] = gdata;
         end else if (rp) begin
            act = 1'b1; g = cyc; gw = 1'b0; last_w = 1'b0;
            gaddr = ifc.i_rd_addr;
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(negedge clk);
         cycle_chk();
         drive();
         model_grant();
         cyc++;
      end
   endtask

   initial begin
      int idx, acks, wes, last_ack;
      ifc.i_wr_req = 0; ifc.i_wr_addr = 0; ifc.i_wr_data = 0;
      ifc.i_rd_req = 0; ifc.i_rd_addr = 0;
      ifc1.i_wr_req = 0; ifc1.i_wr_addr = 0; ifc1.i_wr_data = 0;
      ifc1.i_rd_req = 0; ifc1.i_rd_addr = 0; ifc1.i_sram_dq = 0;
      act = 0; gw = 0; last_w = 0; done_w = 0; done_r = 0; g = 0; cyc = 0;
      gaddr = 0; gdata = 0; m_last_wr = 0; m_rd_data = 0;
      wp = 0; rp = 0; hold_w = 0; hold_r = 0; drop_rd = 0; pw = 0; pr = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = dflt(i);

      repeat (2) @(negedge clk);
      rst = 1'b0;
      mem_clr = 1'b0;
      run(2);  // reset state

      // single write
      wp = 1; ifc.i_wr_addr = 20'h00010; ifc.i_wr_data = 16'hBEEF;
      run(6);
      chk("sram_beef", sram[16], 16'hBEEF);
      chk("last_10", ifc.o_last_wr_addr, 20'h00010);

      // single read
      rp = 1; ifc.i_rd_addr = 20'h00020;
      run(6);
      chk("rd_1234", ifc.o_rd_data, 16'h1234);

      // continuous contention
      hold_w = 1; hold_r = 1; wp = 1; rp = 1;
      ifc.i_wr_addr = 20'h00030; ifc.i_wr_data = 16'h5555; ifc.i_rd_addr = 20'h00031;
      run(15);
      hold_w = 0; hold_r = 0;
      run(10);

      // read request dropped in its first access cycle
      drop_rd = 1; rp = 1; ifc.i_rd_addr = 20'h00030;
      run(6);
      drop_rd = 0;
      chk("drop_rd", ifc.o_rd_data, 16'h5555);

      // random traffic
      pw = 30; pr = 30;
      run(400);
      pw = 0; pr = 0;
      run(12);

      // async reset during the first write cycle
      wp = 1; ifc.i_wr_addr = 20'h00080; ifc.i_wr_data = 16'hCAFE;
      run(1);
      @(negedge clk);
      chk("rst_pre_we", ifc.o_SRAM_WE_N, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("rst_ce", ifc.o_SRAM_CE_N, 1'b1);
      chk("rst_we", ifc.o_SRAM_WE_N, 1'b1);
      chk("rst_oe", ifc.o_SRAM_OE_N, 1'b1);
      chk("rst_lb", ifc.o_SRAM_LB_N, 1'b1);
      chk("rst_ub", ifc.o_SRAM_UB_N, 1'b1);
      chk("rst_dqoe", ifc.o_sram_dq_oe, 1'b0);
      chk("rst_busy", ifc.o_busy, 1'b0);
      chk("rst_ack", ifc.o_wr_ack, 1'b0);
      chk("rst_last", ifc.o_last_wr_addr, 20'd0);
      wp = 0; ifc.i_wr_req = 0;
      repeat (2) @(negedge clk);
      chk("rst_noack", ifc.o_wr_ack, 1'b0);
      rst = 1'b0;
      act = 0; last_w = 0; m_last_wr = 0; m_rd_data = 0; done_w = 0; done_r = 0;
      rp = 1; ifc.i_rd_addr = 20'h00021;
      run(6);
      chk("rst_rd", ifc.o_rd_data, ref_mem[33]);

      // ACCESS_CYC=1: back-to-back writes to 0..7
      idx = 0; acks = 0; wes = 0; last_ack = -1;
      ifc1.i_wr_req = 1; ifc1.i_wr_addr = 0; ifc1.i_wr_data = 16'hA000;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!ifc1.o_SRAM_WE_N) begin
            wes++;
            chk("n1_we_addr", ifc1.o_SRAM_ADDR, 20'(idx));
         end
         if (ifc1.o_wr_ack) begin
            acks++;
            if (last_ack >= 0) chk("n1_gap", k - last_ack, 3);
            last_ack = k;
            idx++;
         end
         ifc1.i_wr_req  = (idx < 8);
         ifc1.i_wr_addr = 20'(idx);
         ifc1.i_wr_data = 16'hA000 + 16'(idx);
      end
      chk("n1_acks", acks, 8);
      chk("n1_wes", wes, 8);
      chk("n1_last", ifc1.o_last_wr_addr, 20'd7);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/aud_sram_arbiter.md
# aud_sram_arbiter

Shares the single 16-bit external SRAM between the audio recorder, which writes samples, and the audio DSP, which reads samples for playback. It sits in the top level between those two requesters and the SRAM pins. Each requester sees a simple request/acknowledge handshake. The block serialises their accesses, applies the SRAM strobe timing, arbitrates round-robin on conflicts, and tracks the last address the recorder wrote.

## Interface
- ACCESS_CYC, 2: SRAM strobe-active cycles per access; legal range 1..15.
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_wr_req  in  1  recorder write request; held until o_wr_ack.
- i_wr_addr  in  20  recorder write address.
- i_wr_data  in  16  recorder write data.
- o_wr_ack  out  1  one-cycle pulse: write completed.
- i_rd_req  in  1  DSP read request; held until o_rd_valid.
- i_rd_addr  in  20  DSP read address.
- o_rd_valid  out  1  one-cycle pulse: o_rd_data updated.
- o_rd_data  out  16  last read word; held between reads.
- o_last_wr_addr  out  20  address of the most recent completed write.
- o_busy  out  1  high whenever the state is not IDLE.
- o_SRAM_ADDR  out  20  SRAM address.
- o_sram_dq  out  16  write data toward the io_SRAM_DQ tristate buffer.
- o_sram_dq_oe  out  1  tristate enable for io_SRAM_DQ.
- i_sram_dq  in  16  read data from io_SRAM_DQ.
- o_SRAM_WE_N, o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  active-low SRAM strobes.

## Operation
- Every output is registered.
- Reset values:
  - All SRAM strobes are 1.
  - o_sram_dq_oe is 0.
  - o_SRAM_ADDR, o_sram_dq, o_rd_data and o_last_wr_addr are 0.
  - o_wr_ack, o_rd_valid and o_busy are 0.
  - The round-robin pointer is set to "read was last", so the first conflict goes to write.
- States: IDLE, WR, RD, DONE. A 4-bit counter cnt runs inside WR and RD.
- IDLE:
  - Requests and payloads are sampled only in this state.
  - Only i_wr_req high: go to WR.
  - Only i_rd_req high: go to RD.
  - Both high: grant the requester that did not win the last grant, then update the pointer.
  - On grant, latch the address (and the data, for a write) and clear cnt.
- WR:
  - CE_N=0, WE_N=1→0 as below, OE_N=1, LB_N=UB_N=0, dq_oe=1, o_sram_dq = latched data.
  - WE_N is 0 for all ACCESS_CYC cycles.
  - When cnt reaches ACCESS_CYC-1, go to DONE. In the same edge, set o_wr_ack=1 and o_last_wr_addr = latched address.
- RD:
  - CE_N=0, OE_N=0, WE_N=1, LB_N=UB_N=0, dq_oe=0.
  - When cnt reaches ACCESS_CYC-1, capture i_sram_dq into o_rd_data at that edge, set o_rd_valid=1, and go to DONE.
- DONE:
  - Lasts exactly one cycle. All strobes are 1 and dq_oe=0; this is the bus turnaround cycle.
  - The ack or valid pulse is visible during this cycle. The next state is IDLE.
- Requester rule: a requester must drop or update its request and payload on the edge that ends its ack/valid cycle. This is natural for a registered requester. No duplicate access results, because DONE never samples requests.
- A request dropped during WR or RD does not abort the access. The access completes and the ack/valid still pulses.
- o_SRAM_ADDR holds its last value in IDLE and DONE.
- Async reset during WR or RD: all strobes go to 1 and dq_oe to 0 immediately, with no ack or valid. The interrupted write is undefined in the SRAM, and o_last_wr_addr returns to 0.

## Timing
- Cycle 0 is the IDLE cycle in which a request is sampled. With N = ACCESS_CYC:
  - Cycles 1..N are WR or RD.
  - Cycle N+1 is DONE, with ack or valid high.
  - Cycle N+2 is IDLE.
- Minimum spacing between accesses is N+2 cycles. With N=2, that is one access per 4 cycles.
- Read data is sampled at the rising edge that ends cycle N. The SRAM must be valid by then; N=2 at 50 MHz gives 40 ns.
- DQ is never driven in a cycle adjacent to OE_N=0, because DONE separates a write from any following read.
- Under continuous contention, grants alternate strictly W, R, W, R…
- Starvation bound: a held request is served within 2(N+2) cycles.

## Test plan
- Single write, N=2: wr_req with addr 0x00010, data 0xBEEF at cycle 0. Expect CE_N=WE_N=0 and dq_oe=1 with DQ=0xBEEF in cycles 1–2. Expect o_wr_ack=1 only in cycle 3, o_last_wr_addr=0x00010 from cycle 3, and IDLE in cycle 4.
- Single read, N=2: SRAM model returns 0x1234 at addr 0x00020, rd_req at cycle 0. Expect OE_N=0 in cycles 1–2 with dq_oe=0, and o_rd_valid=1 with o_rd_data=0x1234 in cycle 3 only.
- Simultaneous requests held continuously for 4 grants after reset. Expect the order W, R, W, R, one access every 4 cycles, with no back-to-back grant to the same requester.
- Back-to-back writes to addresses 0..7 with ACCESS_CYC=1. Expect 8 acks spaced 3 cycles apart, o_last_wr_addr=7, and no duplicate write.
- Request dropped in cycle 1 of a read. Expect the access to complete and o_rd_valid to pulse in cycle 3.
- i_rst asserted in cycle 1 of a write. Expect all strobes at 1, dq_oe=0, o_busy=0 and no ack, immediately and without waiting for a clock edge. After reset release, a new read is served normally.
